e1_rx_cdr: RTL and testbench

E1_RX_CDR -- requirements
Module: e1_rx_cdr

---
 rtl/e1_rx_cdr.sv | 180 ++++++++++++++++++
 tb/tb_e1_rx_cdr.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/e1_rx_cdr.sv
// ---------------------------------------------------------------------------
// e1_rx_cdr -- E1 receive clock/data recovery from a dual-rail pulse line.
//
// The two asynchronous pad lines are synchronised and glitch-filtered. A
// free-running phase counter marks bit periods. Any rising activity on
// either filtered line re-centres the counter. One strobe is emitted per
// recovered bit, carrying which polarities were seen during that bit. A
// loss-of-signal flag rises after LOS_BITS consecutive empty bits.
//
// Parameters
//   PERIOD    nominal bit period in clk cycles (8..63)
//   LOS_BITS  consecutive empty bits before loss-of-signal (1..255)
// Ports
//   clk        single clock, all logic in this domain
//   rst        synchronous active-high reset
//   pad_rx_hi  asynchronous positive-pulse line
//   pad_rx_lo  asynchronous negative-pulse line
//   out_hi     positive pulse seen in the bit just ended (valid with out_stb)
//   out_lo     negative pulse seen in the bit just ended (valid with out_stb)
//   out_stb    one-cycle strobe per recovered bit
//   los        loss-of-signal flag
// ---------------------------------------------------------------------------
module e1_rx_cdr #(
    parameter int PERIOD   = 15,
    parameter int LOS_BITS = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_rx_hi,
    input  logic pad_rx_lo,
    output logic out_hi,
    output logic out_lo,
    output logic out_stb,
    output logic los
);

    localparam logic [5:0] PH_HALF = 6'(PERIOD / 2);
    localparam logic [5:0] PH_LAST = 6'(PERIOD - 1);
    localparam logic [7:0] ZC_MAX  = 8'(LOS_BITS);

    // 2-of-3 majority vote used by the glitch filter
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Bit [1] carries the hi line, bit [0] the lo line, throughout the front end.
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_dly3;
    logic [1:0] r_dly4;
    logic [1:0] r_filt;
    logic [1:0] r_filt_q;

    logic [5:0] r_ph;
    logic       r_hs;
    logic       r_ls;
    logic [7:0] r_zc;
    logic       r_los;
    logic       r_out_hi;
    logic       r_out_lo;
    logic       r_out_stb;

    logic [1:0] w_filt_next;
    logic       w_edge;
    logic       w_bit_end;
    logic [5:0] w_ph_next;
    logic       w_hs_next;
    logic       w_ls_next;
    logic       w_out_hi_next;
    logic       w_out_lo_next;
    logic [7:0] w_zc_next;
    logic       w_los_next;

    // Glitch filter vote over the synchroniser output and its two delayed copies
    always_comb begin
        w_filt_next    = 2'b00;
        w_filt_next[1] = maj3(r_sync2[1], r_dly3[1], r_dly4[1]);
        w_filt_next[0] = maj3(r_sync2[0], r_dly3[0], r_dly4[0]);
    end

    // Start of activity on either line after a quiet cycle re-centres the phase
    assign w_edge    = (r_filt[1] | r_filt[0]) & ~(r_filt_q[1] | r_filt_q[0]);
    assign w_bit_end = (r_ph == PH_LAST);

    // Phase counter, seen flags and output capture
    always_comb begin
        w_ph_next     = r_ph + 6'd1;
        w_hs_next     = r_hs | r_filt[1];
        w_ls_next     = r_ls | r_filt[0];
        w_out_hi_next = r_out_hi;
        w_out_lo_next = r_out_lo;
        // Edge beats bit-end for the phase only; the strobe still fires below.
        if (w_edge) begin
            w_ph_next = PH_HALF;
        end else if (w_bit_end) begin
            w_ph_next = 6'd0;
        end else begin
            w_ph_next = r_ph + 6'd1;
        end
        // At bit-end the current level starts the next bit rather than closing this one.
        if (w_bit_end) begin
            w_hs_next     = r_filt[1];
            w_ls_next     = r_filt[0];
            w_out_hi_next = r_hs;
            w_out_lo_next = r_ls;
        end else begin
            w_hs_next     = r_hs | r_filt[1];
            w_ls_next     = r_ls | r_filt[0];
            w_out_hi_next = r_out_hi;
            w_out_lo_next = r_out_lo;
        end
    end

    // Empty-bit counter and loss-of-signal flag
    always_comb begin
        w_zc_next  = r_zc;
        w_los_next = r_los;
        if (w_edge) begin
            w_zc_next = 8'd0;
        end else if (r_out_stb) begin
            if (r_out_hi | r_out_lo) begin
                w_zc_next = 8'd0;
            end else if (r_zc != ZC_MAX) begin
                w_zc_next = r_zc + 8'd1;
            end else begin
                w_zc_next = r_zc;
            end
        end else begin
            w_zc_next = r_zc;
        end
        if (w_edge) begin
            w_los_next = 1'b0;
        end else if (r_zc == ZC_MAX) begin
            w_los_next = 1'b1;
        end else begin
            w_los_next = r_los;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 2'b00;
            r_sync2   <= 2'b00;
            r_dly3    <= 2'b00;
            r_dly4    <= 2'b00;
            r_filt    <= 2'b00;
            r_filt_q  <= 2'b00;
            r_ph      <= 6'd0;
            r_hs      <= 1'b0;
            r_ls      <= 1'b0;
            r_out_hi  <= 1'b0;
            r_out_lo  <= 1'b0;
            r_out_stb <= 1'b0;
            r_zc      <= ZC_MAX;
            r_los     <= 1'b1;
        end else begin
            r_sync1   <= {pad_rx_hi, pad_rx_lo};
            r_sync2   <= r_sync1;
            r_dly3    <= r_sync2;
            r_dly4    <= r_dly3;
            r_filt    <= w_filt_next;
            r_filt_q  <= r_filt;
            r_ph      <= w_ph_next;
            r_hs      <= w_hs_next;
            r_ls      <= w_ls_next;
            r_out_hi  <= w_out_hi_next;
            r_out_lo  <= w_out_lo_next;
            r_out_stb <= w_bit_end;
            r_zc      <= w_zc_next;
            r_los     <= w_los_next;
        end
    end

    assign out_hi  = r_out_hi;
    assign out_lo  = r_out_lo;
    assign out_stb = r_out_stb;
    assign los     = r_los;

endmodule

// File: tb/tb_e1_rx_cdr.sv
// ---------------------------------------------------------------------------
// tb_e1_rx_cdr -- directed self-checking bench for e1_rx_cdr (default
// parameters: PERIOD 15, LOS_BITS 255).
//
// Timing reference: cyc counts rising clock edges, and every sample and
// drive happens 1 time unit after an edge. When a strobe is observed at
// cyc = s, the phase counter is 0 in that cycle. A pad driven at s is
// first sampled at edge s+1 and appears filtered at s+4, where the edge
// is also seen. The phase is then 7 at s+5 and 14 at s+12, and the
// strobe follows at s+13.
// ---------------------------------------------------------------------------
module tb_e1_rx_cdr;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic pad_rx_hi = 1'b0;
    logic pad_rx_lo = 1'b0;
    logic out_hi;
    logic out_lo;
    logic out_stb;
    logic los;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int   q_cyc[$];
    logic q_hi[$];
    logic q_lo[$];

    int jit[8] = '{0, -3, 3, -1, 2, -2, 1, 3};
    int t_start[8];

    e1_rx_cdr dut (
        .clk       (clk),
        .rst       (rst),
        .pad_rx_hi (pad_rx_hi),
        .pad_rx_lo (pad_rx_lo),
        .out_hi    (out_hi),
        .out_lo    (out_lo),
        .out_stb   (out_stb),
        .los       (los)
    );

    always #5 clk = ~clk;

    // single comparison point
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (out_stb === 1'b1) begin
            q_cyc.push_back(cyc);
            q_hi.push_back(out_hi);
            q_lo.push_back(out_lo);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // advance until a strobe is seen; n = cycles taken, -1 if the bound expires
    task automatic wait_stb(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            step();
            if (out_stb === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int k;
        int good;

        // ---- reset state
        steps(3);
        chk("rst_stb", out_stb, 0);
        chk("rst_hi", out_hi, 0);
        chk("rst_lo", out_lo, 0);
        chk("rst_los", los, 1);

        // ---- idle cadence: phase 0 after the last reset edge, strobe 15 edges later
        rst = 1'b0;
        wait_stb(40, n);
        chk("idle_first", n, 15);
        chk("idle_hi", out_hi, 0);
        chk("idle_lo", out_lo, 0);
        wait_stb(40, n);
        chk("idle_second", n, 15);
        chk("idle_los", los, 1);

        // ---- single 7-cycle hi pulse started at a strobe cycle s
        pad_rx_hi = 1'b1;
        steps(4);                       // s+4: edge cycle, los not yet cleared
        chk("pulse_los_edge", los, 1);
        step();                         // s+5
        chk("pulse_los_clr", los, 0);
        steps(2);                       // s+7
        pad_rx_hi = 1'b0;
        wait_stb(40, n);                // strobe at s+13
        chk("pulse_stb_lat", n, 6);
        chk("pulse_hi", out_hi, 1);
        chk("pulse_lo", out_lo, 0);
        wait_stb(40, n);
        chk("pulse_next_gap", n, 15);
        chk("pulse_next_hi", out_hi, 0);

        // ---- 1-cycle lo glitch at s+2: no edge, cadence unchanged
        steps(2);
        pad_rx_lo = 1'b1;
        step();
        pad_rx_lo = 1'b0;
        wait_stb(40, n);
        chk("glitch_gap", n, 12);
        chk("glitch_lo", out_lo, 0);

        // ---- 2-cycle lo pulse at s: passes the filter, re-centres
        pad_rx_lo = 1'b1;
        steps(2);
        pad_rx_lo = 1'b0;
        wait_stb(40, n);
        chk("lo2_lat", n, 11);
        chk("lo2_lo", out_lo, 1);
        chk("lo2_hi", out_hi, 0);

        // ---- edge in the bit-end cycle: pad at s+10 -> edge at s+14 (ph=14)
        wait_stb(40, n);
        steps(10);
        pad_rx_hi = 1'b1;
        wait_stb(40, n);                // s+15, old flags
        chk("same_stb_lat", n, 5);
        chk("same_stb_hi_old", out_hi, 0);
        steps(2);                       // s+17
        pad_rx_hi = 1'b0;
        wait_stb(40, n);                // s+23, ph restarted at 7 on s+15
        chk("same_next_lat", n, 6);
        chk("same_next_hi", out_hi, 1);

        // ---- alternating jittered pulses: one strobe at start+13 each
        wait_stb(40, n);
        q_cyc.delete();
        q_hi.delete();
        q_lo.delete();
        for (int i = 0; i < 8; i++) begin
            t_start[i] = cyc;
            if (i % 2 == 0) pad_rx_hi = 1'b1;
            else            pad_rx_lo = 1'b1;
            steps(7);
            pad_rx_hi = 1'b0;
            pad_rx_lo = 1'b0;
            steps(8 + jit[i]);
        end
        steps(5);
        k = 0;
        for (int i = 0; i < q_cyc.size(); i++) begin
            if (q_cyc[i] <= t_start[7] + 13) begin
                if (k < 8) begin
                    chk("jit_time", q_cyc[i], t_start[k] + 13);
                    chk("jit_hi", q_hi[i], (k % 2 == 0) ? 1 : 0);
                    chk("jit_lo", q_lo[i], (k % 2 == 1) ? 1 : 0);
                end
                k++;
            end
        end
        chk("jit_count", k, 8);

        // ---- one pulse then silence until loss of signal
        wait_stb(40, n);
        pad_rx_hi = 1'b1;
        steps(7);
        pad_rx_hi = 1'b0;
        wait_stb(40, n);
        chk("los_pulse_lat", n, 6);
        chk("los_pulse_hi", out_hi, 1);
        good = 0;
        for (int i = 0; i < 255; i++) begin
            wait_stb(20, n);
            if (n == 15 && out_hi === 1'b0 && out_lo === 1'b0) good++;
        end
        chk("los_zero_strobes", good, 255);
        chk("los_at_last_stb", los, 0);
        step();                         // zc reaches 255 here
        chk("los_zc_full", los, 0);
        step();
        chk("los_set", los, 1);
        pad_rx_hi = 1'b1;               // new pulse at p
        steps(4);
        chk("los_before_edge", los, 1);
        step();
        chk("los_cleared", los, 0);
        steps(2);
        pad_rx_hi = 1'b0;
        wait_stb(40, n);                // s with out_hi = 1
        chk("rst_pre_hi", out_hi, 1);

        // ---- reset mid-pulse with hs set
        pad_rx_hi = 1'b1;
        steps(8);
        pad_rx_hi = 1'b0;
        rst = 1'b1;
        step();
        chk("midrst_stb", out_stb, 0);
        chk("midrst_hi", out_hi, 0);
        chk("midrst_lo", out_lo, 0);
        chk("midrst_los", los, 1);
        step();
        rst = 1'b0;
        wait_stb(40, n);
        chk("midrst_first", n, 15);
        chk("midrst_first_hi", out_hi, 0);
        wait_stb(40, n);
        chk("midrst_second_hi", out_hi, 0);
        chk("midrst_los_hold", los, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
